// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------------
// | Module   : mem_pkg
// | Purpose  : Shared widths and request type for the SRAM request front-end.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef struct packed {
      logic  we;
      addr_t addr;
      data_t wdata;
   } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------------
// | Module   : sync_fifo
// | Purpose  : Single-clock FIFO, power-of-two depth, head visible on dout.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head is forced to zero when empty so the output is clean out of reset.
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

`default_nettype wire

// File: rtl/mem_req_ctrl.sv
// +----------------------------------------------------------------------------
// | Module   : mem_req_ctrl
// | Purpose  : Credit-limited request master for a 1-cycle-latency SRAM with
// |            in-order read responses through a small FIFO.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module mem_req_ctrl
   import mem_pkg::*;
#(
   parameter int RSP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

   mem_req_t         req_q;
   mem_req_t         req_d;
   logic             s1_q;
   logic             s1_d;
   logic             s2_q;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W:0]   outstanding;
   logic             accept;
   logic             rsp_pop;

   // Every read in flight owns a FIFO slot, so a push can never find it full.
   assign outstanding = {{CNT_W{1'b0}}, s1_q} + {{CNT_W{1'b0}}, s2_q} + {1'b0, fifo_count};
   assign req_ready   = !rst && (outstanding < (CNT_W+1)'(RSP_DEPTH));
   assign accept      = req_valid && req_ready;
   assign rsp_valid   = !fifo_empty;
   assign rsp_pop     = rsp_valid && rsp_ready;

   assign mem_we    = req_q.we;
   assign mem_addr  = req_q.addr;
   assign mem_wdata = req_q.wdata;

   always_comb begin
      req_d    = req_q;
      req_d.we = 1'b0;
      s1_d     = 1'b0;
      if (accept) begin
         req_d = '{we: req_we, addr: req_addr, wdata: req_wdata};
         s1_d  = !req_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= '0;
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
      end else begin
         req_q <= req_d;
         s1_q  <= s1_d;
         s2_q  <= s1_q;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s2_q),
      .pop   (rsp_pop),
      .din   (mem_rdata),
      .dout  (rsp_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   a_credit_holds: assert property (@(posedge clk) disable iff (rst) !(s2_q && fifo_full && !rsp_pop));

endmodule

`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
// +----------------------------------------------------------------------------
// | Module   : tb_mem_req_ctrl
// | Purpose  : Directed self-checking bench for mem_req_ctrl with an SRAM model.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tb_mem_req_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [3:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_rdata;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = '0;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   logic [7:0] got_data [$];
   int         got_cyc  [$];
   int         acc_cyc  [$];
   logic [7:0] sram [16];

   mem_req_ctrl #(.RSP_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural 16x8 SRAM with registered read data.
   always @(posedge clk) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      mem_rdata <= sram[mem_addr];
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) begin
         got_data.push_back(rsp_rdata);
         got_cyc.push_back(cyc);
      end
      if (req_valid && req_ready) acc_cyc.push_back(cyc);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_logs();
      got_data.delete();
      got_cyc.delete();
      acc_cyc.delete();
   endtask

   // Presents one request at posedge+1 and returns at posedge+1 after it is taken.
   task automatic drive(input logic we, input logic [3:0] a, input logic [7:0] d);
      int n = 0;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         nerr++;
         $display("FAIL drive_timeout: req_ready stayed 0, required 1");
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n);
      int b = 0;
      while (got_data.size() < n && b < 60) begin
         @(negedge clk);
         b++;
      end
      @(negedge clk);
      if (got_data.size() < n) begin
         nerr++;
         $display("FAIL rsp_timeout: got %0d responses, required %0d", got_data.size(), n);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
      nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      nvec++; if (rsp_rdata !== 8'd0) begin nerr++; $display("FAIL rst_rsp_rdata: got %0d want 0", rsp_rdata); end
      nvec++; if ({mem_we, mem_addr, mem_wdata} !== 13'd0) begin nerr++; $display("FAIL rst_mem_bus: got we=%b addr=%0d wdata=%0d want 0/0/0", mem_we, mem_addr, mem_wdata); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_stream();
      for (int a = 0; a < 16; a++) drive(1'b1, 4'(a), 8'(a * 3));
      clear_logs();
      for (int a = 0; a < 16; a++) drive(1'b0, 4'(a), 8'hFF);
      wait_rsp(16);
      repeat (3) @(negedge clk);
      nvec++; if (got_data.size() != 16) begin nerr++; $display("FAIL stream_count: got %0d want 16", got_data.size()); end
      nvec++; if (acc_cyc.size() != 16) begin nerr++; $display("FAIL stream_accepts: got %0d want 16", acc_cyc.size()); end
      if (got_data.size() == 16 && acc_cyc.size() == 16) begin
         nvec++; if (got_cyc[0] - acc_cyc[0] != 3) begin nerr++; $display("FAIL stream_latency: got %0d want 3", got_cyc[0] - acc_cyc[0]); end
         for (int i = 0; i < 16; i++) begin
            nvec++; if (got_data[i] !== 8'(i * 3)) begin nerr++; $display("FAIL stream_data[%0d]: got %0d want %0d", i, got_data[i], i * 3); end
            nvec++; if (got_cyc[i] != got_cyc[0] + i) begin nerr++; $display("FAIL stream_rsp_cycle[%0d]: got +%0d want +%0d", i, got_cyc[i] - got_cyc[0], i); end
            nvec++; if (acc_cyc[i] != acc_cyc[0] + i) begin nerr++; $display("FAIL stream_acc_cycle[%0d]: got +%0d want +%0d", i, acc_cyc[i] - acc_cyc[0], i); end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int acc = 0;
      bit take;
      clear_logs();
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         take = req_valid && req_ready;
         @(posedge clk); #1;
         if (take) begin acc++; req_addr = 4'(acc); end
         @(negedge clk);
      end
      nvec++; if (acc != 4) begin nerr++; $display("FAIL bp_accepted: got %0d want 4", acc); end
      nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready_low: got %b want 0", req_ready); end
      nvec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'd0) begin nerr++; $display("FAIL bp_head: got v=%b d=%0d want 1/0", rsp_valid, rsp_rdata); end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready_pop_cycle: got %b want 0", req_ready); end
      @(posedge clk); #1;
      @(negedge clk);
      nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_after_pop: got %b want 1", req_ready); end
      for (int k = 0; k < 20 && acc < 6; k++) begin
         take = req_valid && req_ready;
         @(posedge clk); #1;
         if (take) begin
            acc++; req_addr = 4'(acc);
            if (acc == 6) req_valid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      nvec++; if (acc != 6) begin nerr++; $display("FAIL bp_all_accepted: got %0d want 6", acc); end
      wait_rsp(6);
      repeat (4) @(negedge clk);
      nvec++; if (got_data.size() != 6) begin nerr++; $display("FAIL bp_rsp_count: got %0d want 6", got_data.size()); end
      for (int i = 0; i < 6 && i < got_data.size(); i++) begin
         nvec++; if (got_data[i] !== 8'(i * 3)) begin nerr++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, got_data[i], i * 3); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      clear_logs();
      drive(1'b1, 4'd4, 8'd88);
      nvec++; if (mem_we !== 1'b1 || mem_addr !== 4'd4 || mem_wdata !== 8'd88) begin nerr++; $display("FAIL wr_bus: got we=%b addr=%0d wdata=%0d want 1/4/88", mem_we, mem_addr, mem_wdata); end
      drive(1'b0, 4'd4, 8'd0);
      @(negedge clk);
      nvec++; if (mem_we !== 1'b0 || mem_addr !== 4'd4) begin nerr++; $display("FAIL idle_bus: got we=%b addr=%0d want 0/4", mem_we, mem_addr); end
      wait_rsp(1);
      repeat (3) @(negedge clk);
      nvec++; if (got_data.size() != 1) begin nerr++; $display("FAIL wr_rd_count: got %0d want 1", got_data.size()); end
      if (got_data.size() >= 1 && acc_cyc.size() == 2) begin
         nvec++; if (got_data[0] !== 8'd88) begin nerr++; $display("FAIL wr_rd_data: got %0d want 88", got_data[0]); end
         nvec++; if (got_cyc[0] - acc_cyc[1] != 3) begin nerr++; $display("FAIL wr_rd_latency: got %0d want 3", got_cyc[0] - acc_cyc[1]); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      clear_logs();
      drive(1'b1, 4'd11, 8'd200);
      drive(1'b0, 4'd11, 8'd0);
      wait_rsp(1);
      nvec++; if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 1) begin nerr++; $display("FAIL b2b_no_bubble: got %0d accepts, want 2 on adjacent cycles", acc_cyc.size()); end
      nvec++; if (got_data.size() < 1 || got_data[0] !== 8'd200) begin nerr++; $display("FAIL b2b_new_data: got %0d want 200", got_data.size() ? got_data[0] : 8'd0); end
      @(posedge clk); #1;
   endtask

   task automatic test_read_write_order();
      clear_logs();
      drive(1'b0, 4'd4, 8'd0);
      drive(1'b1, 4'd4, 8'd7);
      drive(1'b0, 4'd4, 8'd0);
      wait_rsp(2);
      nvec++; if (got_data.size() != 2) begin nerr++; $display("FAIL rw_count: got %0d want 2", got_data.size()); end
      if (got_data.size() == 2) begin
         nvec++; if (got_data[0] !== 8'd88) begin nerr++; $display("FAIL rw_old_data: got %0d want 88", got_data[0]); end
         nvec++; if (got_data[1] !== 8'd7) begin nerr++; $display("FAIL rw_new_data: got %0d want 7", got_data[1]); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit seen_valid = 1'b0;
      clear_logs();
      drive(1'b0, 4'd0, 8'd0);
      drive(1'b0, 4'd1, 8'd0);
      rst = 1'b1;
      @(negedge clk);
      nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL mid_rst_ready: got %b want 0", req_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL mid_rst_release_ready: got %b want 1", req_ready); end
      for (int k = 0; k < 8; k++) begin
         if (rsp_valid) seen_valid = 1'b1;
         @(negedge clk);
      end
      nvec++; if (seen_valid || got_data.size() != 0) begin nerr++; $display("FAIL mid_rst_dropped: got %0d responses want 0", got_data.size()); end
      @(posedge clk); #1;
      drive(1'b0, 4'd11, 8'd0);
      wait_rsp(1);
      nvec++; if (got_data.size() != 1 || got_data[0] !== 8'd200) begin nerr++; $display("FAIL mid_rst_after_read: got %0d responses, want one of 200", got_data.size()); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) sram[i] = 8'd0;
      test_reset();
      test_stream();
      test_backpressure();
      test_write_read();
      test_back_to_back();
      test_read_write_order();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire
